// File: rtl/mem_param.sv
// Parametrised single-port synchronous RAM with an optional post-reset zero-clear sweep.
// Registered read data with valid strobe, busy while clearing, error pulse on rejected requests.
module mem_param #(
    parameter int DW         = 8,
    parameter int AW         = 4,
    parameter int DEPTH      = 16,
    parameter int CLR_ON_RST = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic          rd,
    input  logic [AW-1:0] ad,
    input  logic [DW-1:0] Datain,
    output logic [DW-1:0] Dataout,
    output logic          rd_valid,
    output logic          busy,
    output logic          err
);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t      LP_RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
    localparam logic        LP_RST_BUSY  = (CLR_ON_RST != 0) ? 1'b1 : 1'b0;
    localparam int          LP_LAST_I    = DEPTH - 1;
    // Pointer and range compare are AW+1 bits so DEPTH=2**AW is representable.
    localparam logic [AW:0] LP_DEPTH     = DEPTH[AW:0];
    localparam logic [AW:0] LP_LAST      = LP_LAST_I[AW:0];
    localparam logic [AW:0] LP_ONE       = {{AW{1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_next_state;
    logic [AW:0]   r_ptr;
    logic [AW:0]   w_ptr_next;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_in_range;
    logic          w_req;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic          w_rd_valid_next;
    logic          w_err_next;
    logic [DW-1:0] w_dout_next;

    assign w_in_range = ({1'b0, ad} < LP_DEPTH);
    assign w_req      = wr | rd;

    // FSM state and clear-pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LP_RST_STATE;
            r_ptr   <= {(AW+1){1'b0}};
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_ptr_next;
        end
    end

    // Next-state, memory write port and next output values
    always_comb begin
        w_next_state    = r_state;
        w_ptr_next      = r_ptr;
        w_we            = 1'b0;
        w_waddr         = ad;
        w_wdata         = Datain;
        w_rd_valid_next = 1'b0;
        w_err_next      = 1'b0;
        w_dout_next     = Dataout;
        case (r_state)
            ST_CLEAR: begin
                w_we       = 1'b1;
                w_waddr    = r_ptr[AW-1:0];
                w_wdata    = {DW{1'b0}};
                w_ptr_next = r_ptr + LP_ONE;
                w_err_next = w_req;
                if (r_ptr == LP_LAST) begin
                    w_next_state = ST_READY;
                end else begin
                    w_next_state = ST_CLEAR;
                end
            end
            ST_READY: begin
                w_we       = wr & w_in_range;
                w_err_next = w_req & ~w_in_range;
                // Read-first: the array still holds the old word on a same-edge write.
                if (rd) begin
                    w_rd_valid_next = 1'b1;
                    if (w_in_range) begin
                        w_dout_next = r_mem[ad];
                    end else begin
                        w_dout_next = {DW{1'b0}};
                    end
                end else begin
                    w_dout_next = Dataout;
                end
            end
            default: begin
                w_next_state = ST_READY;
            end
        endcase
    end

    // Storage array, intentionally without reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Dataout  <= {DW{1'b0}};
            rd_valid <= 1'b0;
            err      <= 1'b0;
            busy     <= LP_RST_BUSY;
        end else begin
            Dataout  <= w_dout_next;
            rd_valid <= w_rd_valid_next;
            err      <= w_err_next;
            busy     <= (w_next_state == ST_CLEAR);
        end
    end

endmodule

// File: tb/tb_mem_param.sv
// Self-checking bench for mem_param: a DEPTH=16 and a DEPTH=12 instance share stimulus,
// each is tracked by a behavioural model and checked every cycle, plus literal expectations.
module tb_mem_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr, rd;
    logic [3:0] ad;
    logic [7:0] din;

    logic [7:0] do16, do12;
    logic       rv16, rv12, bz16, bz12, er16, er12;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mem_param #(.DW(8), .AW(4), .DEPTH(16), .CLR_ON_RST(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .ad(ad), .Datain(din),
        .Dataout(do16), .rd_valid(rv16), .busy(bz16), .err(er16)
    );

    mem_param #(.DW(8), .AW(4), .DEPTH(12), .CLR_ON_RST(1)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .ad(ad), .Datain(din),
        .Dataout(do12), .rd_valid(rv12), .busy(bz12), .err(er12)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: index 0 is DEPTH=16, index 1 is DEPTH=12
    int         dep [2] = '{16, 12};
    logic [7:0] mm [2][16];
    int         clr_left [2];
    logic [7:0] e_do [2];
    logic       e_rv [2], e_err [2], e_busy [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                clr_left[k] = dep[k];
                e_do[k]     = 8'h00;
                e_rv[k]     = 1'b0;
                e_err[k]    = 1'b0;
            end else if (clr_left[k] > 0) begin
                mm[k][dep[k] - clr_left[k]] = 8'h00;
                e_rv[k]  = 1'b0;
                e_err[k] = wr | rd;
                clr_left[k]--;
            end else begin
                e_rv[k]  = rd;
                e_err[k] = (wr | rd) && (int'(ad) >= dep[k]);
                if (rd) e_do[k] = (int'(ad) < dep[k]) ? mm[k][ad] : 8'h00;
                if (wr && int'(ad) < dep[k]) mm[k][ad] = din;
            end
            e_busy[k] = (clr_left[k] > 0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout16", do16, e_do[0]);
            chk("rv16", {7'd0, rv16}, {7'd0, e_rv[0]});
            chk("err16", {7'd0, er16}, {7'd0, e_err[0]});
            chk("busy16", {7'd0, bz16}, {7'd0, e_busy[0]});
            chk("dout12", do12, e_do[1]);
            chk("rv12", {7'd0, rv12}, {7'd0, e_rv[1]});
            chk("err12", {7'd0, er12}, {7'd0, e_err[1]});
            chk("busy12", {7'd0, bz12}, {7'd0, e_busy[1]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy16 falls; also records when busy12 fell.
    task automatic count_sweep(output int n16, output int n12);
        n16 = 0;
        n12 = -1;
        while (bz16 && n16 < 40) begin
            cyc();
            n16++;
            if (n12 < 0 && !bz12) n12 = n16;
        end
    endtask

    int n, m;

    initial begin
        wr = 1'b0; rd = 1'b0; ad = 4'd0; din = 8'h00;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_busy16", {7'd0, bz16}, 8'h01);
        chk("rst_dout16", do16, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Clear sweep length, then every word reads back zero
        count_sweep(n, m);
        chk("clr_edges16", n[7:0], 8'd16);
        chk("clr_edges12", m[7:0], 8'd12);
        for (int a = 0; a < 16; a++) begin
            rd = 1'b1; ad = a[3:0];
            cyc();
            chk("clr_rd16", do16, 8'h00);
            chk("clr_rv16", {7'd0, rv16}, 8'h01);
        end
        rd = 1'b0;

        // Write then read back on consecutive cycles
        wr = 1'b1; ad = 4'd3; din = 8'hA5; cyc();
        ad = 4'd15; din = 8'h5A; cyc();
        wr = 1'b0; rd = 1'b1; ad = 4'd3; cyc();
        chk("wr_rd3", do16, 8'hA5);
        chk("wr_rv3", {7'd0, rv16}, 8'h01);
        chk("wr_err3", {7'd0, er16}, 8'h00);
        ad = 4'd15; cyc();
        chk("wr_rd15", do16, 8'h5A);
        chk("wr_rv15", {7'd0, rv16}, 8'h01);
        rd = 1'b0;

        // Read-first collision
        wr = 1'b1; ad = 4'd7; din = 8'h11; cyc();
        rd = 1'b1; din = 8'h22; cyc();
        chk("coll_old", do16, 8'h11);
        chk("coll_err", {7'd0, er16}, 8'h00);
        wr = 1'b0; cyc();
        chk("coll_new", do16, 8'h22);
        rd = 1'b0; cyc();
        chk("idle_rv", {7'd0, rv16}, 8'h00);
        chk("idle_hold", do16, 8'h22);

        // Out of range on the DEPTH=12 instance
        wr = 1'b1; ad = 4'd11; din = 8'h3C; cyc();
        ad = 4'd13; din = 8'hFF; cyc();
        chk("oor_wr_err", {7'd0, er12}, 8'h01);
        chk("oor_wr_rv", {7'd0, rv12}, 8'h00);
        wr = 1'b0; rd = 1'b1; cyc();
        chk("oor_rd_err", {7'd0, er12}, 8'h01);
        chk("oor_rd_rv", {7'd0, rv12}, 8'h01);
        chk("oor_rd_dout", do12, 8'h00);
        chk("inr_rd13", do16, 8'hFF);
        ad = 4'd11; cyc();
        chk("oor_keep11", do12, 8'h3C);
        chk("oor_err11", {7'd0, er12}, 8'h00);

        // Reset while a read result is valid
        ad = 4'd5; cyc();
        rd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rrd_dout", do16, 8'h00);
        chk("rrd_rv", {7'd0, rv16}, 8'h00);
        chk("rrd_busy", {7'd0, bz16}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;

        // Request rejected on edge 3 of the sweep; sweep still ends at edge 16
        n = 0;
        while (bz16 && n < 40) begin
            rd = (n == 2);
            cyc();
            n++;
            if (n == 3) begin
                chk("rej_err", {7'd0, er16}, 8'h01);
                chk("rej_rv", {7'd0, rv16}, 8'h00);
            end
            if (n == 4) chk("rej_err_end", {7'd0, er16}, 8'h00);
        end
        rd = 1'b0;
        chk("rej_edges", n[7:0], 8'd16);

        // Reset mid-sweep at ptr=9, then a full restart
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < 9) begin
            cyc();
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {7'd0, bz16}, 8'h01);
        chk("mid_dout", do16, 8'h00);
        chk("mid_rv", {7'd0, rv16}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        count_sweep(n, m);
        chk("mid_edges16", n[7:0], 8'd16);
        rd = 1'b1; ad = 4'd3; cyc();
        chk("mid_rd3", do16, 8'h00);
        rd = 1'b0; cyc();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_param.md
# mem_param

Parametrised single-port synchronous RAM. It is the successor to the fixed 8-bit x 16 scratch memory in the Week1 datapath. It adds configurable width and depth, optional hardware zero-clear after reset, a read-valid strobe and out-of-range error reporting. Dataout holds its last value when idle and is never driven to Z. It sits between the controller FSM and the datapath as general-purpose storage.

## Interface
- DW, 8: data width in bits
- AW, 4: address width in bits
- DEPTH, 16: number of words; must satisfy 1 <= DEPTH <= 2**AW
- CLR_ON_RST, 1: 1 runs a hardware zero-clear sweep after reset; 0 leaves contents undefined after power-up
- clk  input  1  sole clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- wr  input  1  write request, sampled on rising clk
- rd  input  1  read request, sampled on rising clk
- ad  input  AW  word address
- Datain  input  DW  write data
- Dataout  output  DW  registered read data
- rd_valid  output  1  one-cycle pulse; Dataout is updated this cycle
- busy  output  1  clear sweep in progress; requests are ignored
- err  output  1  one-cycle pulse on a rejected request

## Operation
- The FSM has two states, CLEAR and READY.
- On rst_n low, the block asynchronously enters CLEAR if CLR_ON_RST=1, otherwise READY.
- The clear pointer resets to 0.
- Output reset values: Dataout=0, rd_valid=0, err=0, busy=CLR_ON_RST.
- The memory array itself has no reset.
- CLEAR state:
  - Each cycle writes 0 to A[ptr], then ptr increments.
  - After the write to ptr=DEPTH-1, the FSM goes to READY and busy falls.
  - Any wr or rd sampled in CLEAR is dropped, pulses err, and gives no rd_valid.
- READY state, write (wr=1, ad<DEPTH): A[ad] <= Datain.
- READY state, read (rd=1, ad<DEPTH): Dataout <= A[ad] and rd_valid=1 on the same edge.
- wr=1 and rd=1 together on the same address is read-first:
  - Dataout returns the old contents.
  - The write completes on the same edge.
  - No err.
- Out of range (ad>=DEPTH, only possible when DEPTH<2**AW):
  - A write is dropped.
  - A read loads Dataout=0 and still pulses rd_valid.
  - err pulses.
- wr=0 and rd=0: Dataout holds its value; rd_valid=0; err=0.
- rd_valid and err are registered and deassert the cycle after any cycle without a qualifying event.
- Width rules:
  - ptr is AW+1 bits wide, so DEPTH=2**AW terminates without wrap.
  - The ad>=DEPTH compare is done at AW+1 bits.

## Timing
- Read latency is 1 cycle: request at edge N, Dataout and rd_valid valid after edge N, until edge N+1.
- Back-to-back reads every cycle are supported; rd_valid stays high continuously.
- A write is visible to a read issued on the next edge; write-then-read latency is 1 cycle.
- Clear duration:
  - The first clear write happens on the first rising edge after rst_n deasserts.
  - busy is low after DEPTH edges.
  - The first accepted request is on edge DEPTH+1.
- Reset mid-clear or mid-read:
  - Outputs return to reset values immediately and asynchronously.
  - A pending rd_valid is lost.
  - The sweep restarts from address 0 when rst_n rises.
- rst_n deassertion is synchronised externally; the block does not re-synchronise it.

## Test plan
- Clear sweep, defaults: release rst_n and count edges with busy=1 (required: 16); then read addresses 0..15 (required: each returns 0x00 with rd_valid high).
- Write/read: write 0xA5 to addr 3 and 0x5A to addr 15; read 3 then 15 on consecutive cycles (required: Dataout 0xA5 then 0x5A, rd_valid high for 2 cycles, err=0).
- Read-first collision: addr 7 holds 0x11; assert wr=1, rd=1, ad=7, Datain=0x22 (required: Dataout=0x11); next cycle read addr 7 (required: 0x22).
- Rejection during clear: assert rd=1 on edge 3 of the sweep (required: err pulses once, no rd_valid, sweep still finishes at edge 16).
- Out of range with DEPTH=12, AW=4: write 0xFF to addr 13 and read addr 13 (required: err pulses each time, read gives Dataout=0 with rd_valid=1); addr 11 (required: unaffected).
- Reset mid-operation: pull rst_n low during the sweep at ptr=9 (required: Dataout=0, rd_valid=0, busy=1 immediately); release (required: busy=1 for 16 more edges).
